// File: rtl/maze_solver_ext.sv
// -----------------------------------------------------------------------------
// maze_solver_ext
// Wall-following maze walker. Starting from a given cell and heading it keeps
// one hand on the wall: it first tries the cell on the hand side, then the cell
// ahead, and turns away from the hand until a free cell is found. Every visited
// cell is marked in the maze memory. A solve ends on reaching a boundary cell
// (exit), after MAX_STEPS moves (timeout), or when all four headings are walled
// (trapped).
//
// Ports
//   clk, rst_n                 clock (posedge), asynchronous active-low reset
//   start                      begin a solve; accepted only when idle or done
//   starting_row/col/dir, hand start cell, heading (0=N 1=E 2=S 3=W) and hand
//                              (0=right wall, 1=left wall), latched with start
//   maze_in                    memory read data (1=wall), valid one cycle after maze_oe
//   row, col                   memory address
//   maze_oe, maze_we           read strobe / path-mark write strobe
//   busy, done                 solve in progress / solve finished
//   result                     01=exit 10=step limit 11=trapped (valid with done)
//   steps                      moves made in the current or last solve
// -----------------------------------------------------------------------------
module maze_solver_ext #(
   parameter int ROW_W     = 6,
   parameter int COL_W     = 6,
   parameter int MAX_ROW   = (1 << ROW_W) - 1,
   parameter int MAX_COL   = (1 << COL_W) - 1,
   parameter int STEP_W    = 12,
   parameter int MAX_STEPS = 4095
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ROW_W-1:0]  starting_row,
   input  logic [COL_W-1:0]  starting_col,
   input  logic [1:0]        starting_dir,
   input  logic              hand,
   input  logic              maze_in,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic              maze_oe,
   output logic              maze_we,
   output logic              busy,
   output logic              done,
   output logic [1:0]        result,
   output logic [STEP_W-1:0] steps
);

   localparam logic [ROW_W:0]    MAX_ROW_X = (ROW_W+1)'(MAX_ROW);
   localparam logic [COL_W:0]    MAX_COL_X = (COL_W+1)'(MAX_COL);
   localparam logic [ROW_W-1:0]  MAX_ROW_V = ROW_W'(MAX_ROW);
   localparam logic [COL_W-1:0]  MAX_COL_V = COL_W'(MAX_COL);
   localparam logic [STEP_W-1:0] STEP_LIM  = STEP_W'(MAX_STEPS);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_PROBE_S = 3'd2,
      ST_EVAL_S  = 3'd3,
      ST_PROBE_F = 3'd4,
      ST_EVAL_F  = 3'd5,
      ST_MOVE    = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  cur_row_q, cur_row_d;
   logic [COL_W-1:0]  cur_col_q, cur_col_d;
   logic [1:0]        dir_q, dir_d;
   logic              hand_q, hand_d;
   logic [1:0]        turn_q, turn_d;
   logic              off_q, off_d;     // last probe was off-grid: read as wall
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              oe_q, oe_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [1:0]        result_q, result_d;
   logic [STEP_W-1:0] steps_q, steps_d;

   // Neighbour of (r,c) in heading d; computed one bit wider so that stepping
   // below 0 or past the last row/column shows up as off-grid.
   function automatic logic [ROW_W+COL_W:0] nb_f(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c,
                                                input logic [1:0]       d);
      logic [ROW_W:0] rw;
      logic [COL_W:0] cw;
      rw = {1'b0, r};
      cw = {1'b0, c};
      case (d)
         2'd0:    rw = {1'b0, r} - {{ROW_W{1'b0}}, 1'b1};
         2'd1:    cw = {1'b0, c} + {{COL_W{1'b0}}, 1'b1};
         2'd2:    rw = {1'b0, r} + {{ROW_W{1'b0}}, 1'b1};
         default: cw = {1'b0, c} - {{COL_W{1'b0}}, 1'b1};
      endcase
      return {(rw > MAX_ROW_X) | (cw > MAX_COL_X), rw[ROW_W-1:0], cw[COL_W-1:0]};
   endfunction

   logic [1:0]       side_dir_s, back_dir_s;
   logic             side_off_s, fwd_off_s, back_off_s;
   logic [ROW_W-1:0] side_row_s, fwd_row_s, back_row_s;
   logic [COL_W-1:0] side_col_s, fwd_col_s, back_col_s;
   logic             wall_s, at_edge_s;

   assign side_dir_s = hand_q ? (dir_q - 2'd1) : (dir_q + 2'd1);
   assign back_dir_s = hand_q ? (dir_q + 2'd1) : (dir_q - 2'd1);
   assign {side_off_s, side_row_s, side_col_s} = nb_f(cur_row_q, cur_col_q, side_dir_s);
   assign {fwd_off_s,  fwd_row_s,  fwd_col_s}  = nb_f(cur_row_q, cur_col_q, dir_q);
   assign {back_off_s, back_row_s, back_col_s} = nb_f(cur_row_q, cur_col_q, back_dir_s);
   assign wall_s    = off_q | maze_in;
   assign at_edge_s = (cur_row_q == {ROW_W{1'b0}}) | (cur_row_q == MAX_ROW_V) |
                      (cur_col_q == {COL_W{1'b0}}) | (cur_col_q == MAX_COL_V);

   logic             go_move_s, go_prb_s, prb_off_s;
   logic [ROW_W-1:0] tgt_row_s, prb_row_s;
   logic [COL_W-1:0] tgt_col_s, prb_col_s;

   // Next-state and next-output logic; outputs are set on entry to the state
   // they belong to, so every output comes straight from a flop.
   always_comb begin
      state_d   = state_q;   cur_row_d = cur_row_q; cur_col_d = cur_col_q;
      dir_d     = dir_q;     hand_d    = hand_q;    turn_d    = turn_q;
      off_d     = off_q;     row_d     = row_q;     col_d     = col_q;
      oe_d      = 1'b0;      we_d      = 1'b0;      busy_d    = busy_q;
      done_d    = done_q;    result_d  = result_q;  steps_d   = steps_q;
      go_move_s = 1'b0;      tgt_row_s = fwd_row_s; tgt_col_s = fwd_col_s;
      go_prb_s  = 1'b0;      prb_off_s = side_off_s;
      prb_row_s = side_row_s; prb_col_s = side_col_s;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_START;
               cur_row_d = starting_row;  cur_col_d = starting_col;
               row_d     = starting_row;  col_d     = starting_col;
               dir_d     = starting_dir;  hand_d    = hand;
               we_d      = 1'b1;          busy_d    = 1'b1;
               done_d    = 1'b0;          result_d  = 2'b00;
               steps_d   = {STEP_W{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         ST_START: begin
            state_d  = ST_PROBE_S;
            turn_d   = 2'd0;
            go_prb_s = 1'b1;
         end
         ST_PROBE_S: state_d = ST_EVAL_S;
         ST_EVAL_S: begin
            if (!wall_s) begin
               dir_d     = side_dir_s;
               go_move_s = 1'b1;
               tgt_row_s = side_row_s;  tgt_col_s = side_col_s;
            end else begin
               state_d   = ST_PROBE_F;
               go_prb_s  = 1'b1;
               prb_off_s = fwd_off_s;
               prb_row_s = fwd_row_s;   prb_col_s = fwd_col_s;
            end
         end
         ST_PROBE_F: state_d = ST_EVAL_F;
         ST_EVAL_F: begin
            if (!wall_s) begin
               go_move_s = 1'b1;
            end else if (turn_q == 2'd3) begin
               // fourth turn in a row without moving: boxed in
               dir_d    = back_dir_s;
               state_d  = ST_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               result_d = 2'b11;
            end else begin
               dir_d     = back_dir_s;
               turn_d    = turn_q + 2'd1;
               state_d   = ST_PROBE_F;
               go_prb_s  = 1'b1;
               prb_off_s = back_off_s;
               prb_row_s = back_row_s;  prb_col_s = back_col_s;
            end
         end
         ST_MOVE: begin
            // exit is checked before the step limit
            if (at_edge_s) begin
               state_d  = ST_DONE;  busy_d = 1'b0;  done_d = 1'b1;  result_d = 2'b01;
            end else if (steps_q == STEP_LIM) begin
               state_d  = ST_DONE;  busy_d = 1'b0;  done_d = 1'b1;  result_d = 2'b10;
            end else begin
               state_d  = ST_PROBE_S;
               go_prb_s = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (go_move_s) begin
         state_d   = ST_MOVE;
         cur_row_d = tgt_row_s;  cur_col_d = tgt_col_s;
         row_d     = tgt_row_s;  col_d     = tgt_col_s;
         we_d      = 1'b1;
         turn_d    = 2'd0;
         steps_d   = (steps_q == STEP_LIM) ? steps_q : (steps_q + STEP_W'(1));
      end else if (go_prb_s) begin
         // an off-grid neighbour is never read; it is taken as a wall
         off_d = prb_off_s;
         oe_d  = ~prb_off_s;
         if (prb_off_s) begin
            row_d = row_q;      col_d = col_q;
         end else begin
            row_d = prb_row_s;  col_d = prb_col_s;
         end
      end else begin
         off_d = off_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cur_row_q <= {ROW_W{1'b0}};  cur_col_q <= {COL_W{1'b0}};
         dir_q     <= 2'd0;           hand_q    <= 1'b0;
         turn_q    <= 2'd0;           off_q     <= 1'b0;
         row_q     <= {ROW_W{1'b0}};  col_q     <= {COL_W{1'b0}};
         oe_q      <= 1'b0;           we_q      <= 1'b0;
         busy_q    <= 1'b0;           done_q    <= 1'b0;
         result_q  <= 2'b00;          steps_q   <= {STEP_W{1'b0}};
      end else begin
         state_q   <= state_d;
         cur_row_q <= cur_row_d;      cur_col_q <= cur_col_d;
         dir_q     <= dir_d;          hand_q    <= hand_d;
         turn_q    <= turn_d;         off_q     <= off_d;
         row_q     <= row_d;          col_q     <= col_d;
         oe_q      <= oe_d;           we_q      <= we_d;
         busy_q    <= busy_d;         done_q    <= done_d;
         result_q  <= result_d;       steps_q   <= steps_d;
      end
   end

   assign row     = row_q;
   assign col     = col_q;
   assign maze_oe = oe_q;
   assign maze_we = we_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
   assign steps   = steps_q;

endmodule

// File: tb/tb_maze_solver_ext.sv
// -----------------------------------------------------------------------------
// tb_maze_solver_ext
// Bench for maze_solver_ext on an 8x8 grid with a 10-move limit. A behavioural
// maze memory (1-cycle read latency) and an access monitor surround the DUT.
// Each vector record holds a start request and the expected outcome; the
// expectation is queued when the start is driven and checked when done rises.
// -----------------------------------------------------------------------------
module tb_maze_solver_ext;

   localparam int RW = 3;
   localparam int CW = 3;
   localparam int SW = 12;
   localparam int MS = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [RW-1:0] srow = 3'd0;
   logic [CW-1:0] scol = 3'd0;
   logic [1:0]    sdir = 2'd0;
   logic          hand_i = 1'b0;
   logic          maze_in = 1'b0;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic          oe, we, busy, done;
   logic [1:0]    result;
   logic [SW-1:0] steps;

   maze_solver_ext #(.ROW_W(RW), .COL_W(CW), .STEP_W(SW), .MAX_STEPS(MS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .starting_row(srow), .starting_col(scol), .starting_dir(sdir), .hand(hand_i),
      .maze_in(maze_in), .row(row), .col(col), .maze_oe(oe), .maze_we(we),
      .busy(busy), .done(done), .result(result), .steps(steps)
   );

   always #5 clk = ~clk;

   logic mem [0:7][0:7];

   // Maze memory: read data appears the cycle after the strobe.
   always @(posedge clk) maze_in <= (rst_n && oe) ? mem[row][col] : 1'b0;

   int         n_rd = 0, n_wr = 0, cyc = 0, both_err = 0;
   int         we_cyc[$];
   logic [5:0] wr_log[$];

   // Access monitor: counts reads/writes and logs every marked cell.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n) begin
         if (oe) n_rd <= n_rd + 1;
         if (we) begin
            n_wr <= n_wr + 1;
            we_cyc.push_back(cyc);
            wr_log.push_back({row, col});
         end
         if (oe && we) both_err <= both_err + 1;
      end
   end

   typedef struct {
      int r, c, d, h, mz;
      int res, stp, fr, fc, nwr, nrd;
   } vec_t;

   vec_t vecs[6];
   vec_t exp_q[$];
   int   tests = 0, fails = 0;
   int   rd0, wr0, base0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load_maze(input int id);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            case (id)
               0: mem[r][c] = (r == 4);
               1: mem[r][c] = !(r == 3 && c >= 1);
               2: mem[r][c] = 1'b1;
               3: mem[r][c] = !((r >= 2 && r <= 5 && c >= 2 && c <= 5) &&
                                (r == 2 || r == 5 || c == 2 || c == 5));
               4: mem[r][c] = !((r == 1 && c >= 2 && c <= 6) || (c == 6 && r >= 2));
               default: mem[r][c] = !(c == 3);
            endcase
         end
      end
   endtask

   task automatic drive_start(input vec_t v);
      @(negedge clk);
      load_maze(v.mz);
      rd0 = n_rd; wr0 = n_wr; base0 = wr_log.size();
      srow = 3'(v.r); scol = 3'(v.c); sdir = 2'(v.d); hand_i = v.h[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int   k;
      vec_t e;
      drive_start(v);
      exp_q.push_back(v);
      chk("busy_done_after_start", {busy, done}, 2);
      k = 0;
      while (!done && k < 400) begin
         @(negedge clk);
         k++;
      end
      e = exp_q.pop_front();
      chk("done_reached", done, 1);
      if (done) begin
         chk("result", result, e.res);
         chk("steps", steps, e.stp);
         chk("final_row", row, e.fr);
         chk("final_col", col, e.fc);
         chk("writes", n_wr - wr0, e.nwr);
         chk("reads", n_rd - rd0, e.nrd);
         chk("busy_low_when_done", busy, 0);
      end
   endtask

   task automatic chk_gaps(input int first_gap);
      for (int j = base0; j + 1 < we_cyc.size(); j++)
         chk("we_gap", we_cyc[j+1] - we_cyc[j], (j == base0) ? first_gap : 5);
   endtask

   task automatic chk_path1();
      chk("path_len", wr_log.size() - base0, 5);
      for (int j = 0; j < 5; j++)
         if (base0 + j < wr_log.size())
            chk("path_cell", wr_log[base0+j], {3'd3, 3'(3 + j)});
   endtask

   initial begin
      int nwe, k;
      //           r  c  d  h  mz res stp fr fc nwr nrd
      vecs[0] = '{3, 3, 0, 0, 0, 1, 4,  3, 7, 5,  7};   // wall below row 3, exit east
      vecs[1] = '{3, 1, 1, 1, 1, 1, 6,  3, 7, 7,  12};  // corridor, all forward moves
      vecs[2] = '{4, 4, 0, 0, 2, 3, 0,  4, 5, 1,  5};   // boxed in
      vecs[3] = '{2, 2, 1, 0, 3, 2, 10, 2, 4, 11, 22};  // ring, step limit
      vecs[4] = '{1, 2, 1, 1, 4, 1, 10, 7, 6, 11, 21};  // exit on the limit move
      vecs[5] = '{0, 3, 0, 0, 5, 1, 7,  7, 3, 8,  15};  // boundary start, off-grid probe

      repeat (3) @(negedge clk);
      chk("reset_outputs", {row, col, oe, we, busy, done, result, steps}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         if (i == 0) begin
            chk_path1();
            chk_gaps(3);
         end
         if (i == 1) chk_gaps(5);
         if (i == 3) begin
            repeat (20) @(negedge clk);
            chk("hold_done", done, 1);
            chk("hold_result", result, 2);
            chk("hold_steps", steps, 10);
         end
         if (i == 5) begin
            chk("t6_log_len_ok", (wr_log.size() > base0 + 1) ? 1 : 0, 1);
            if (wr_log.size() > base0 + 1)
               chk("t6_first_move", wr_log[base0+1], {3'd1, 3'd3});
         end
      end

      // Reset during the second move of the first walk, then replay it.
      drive_start(vecs[0]);
      nwe = 0; k = 0;
      while (nwe < 3 && k < 200) begin
         if (we) nwe++;
         if (nwe < 3) begin
            @(negedge clk);
            k++;
         end
      end
      chk("t5_reach_move2", nwe, 3);
      chk("t5_move2_cell", {row, col}, {3'd3, 3'd5});
      rst_n = 1'b0;
      #1;
      chk("t5_async_clear", {row, col, oe, we, busy, done, result, steps}, 0);
      @(posedge clk);
      #1;
      chk("t5_held_clear", {row, col, oe, we, busy, done, result, steps}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[0]);
      chk_path1();
      chk_gaps(3);

      chk("oe_we_exclusive", both_err, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
